fifo_bank: RTL
==============

# fifo_bank

Bank of FIFO_UNITS independent synchronous FIFOs that buffer the 10-bit words routed by class (bits [9:8]) from the demux. It receives the per-FIFO push/pop vectors computed by the arbitration logic and returns the per-FIFO empty and almost-full status that the arbiter uses for its next decision. It sits directly downstream of the push-condition arbiter and upstream of the output stage.

## Interface
- FIFO_UNITS, 4, number of FIFOs; one per traffic class.
- WORD_SIZE, 10, word width; [9:8] is the class and [7:0] is the payload.
- FIFO_DEPTH, 8, entries per FIFO; must be a power of two, ≥ 4.
- ALMOST_FULL_LEVEL, 6, occupancy at which almost_full asserts; must satisfy 1 ≤ level < FIFO_DEPTH.
- PTR_W, $clog2(FIFO_DEPTH), derived; do not override.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the whole bank.
- push_data  in  WORD_SIZE  write word, shared by all FIFOs.
- push  in  FIFO_UNITS  per-FIFO push request; normally one-hot.
- pop  in  FIFO_UNITS  per-FIFO pop request; any combination is allowed.
- pop_data  out  FIFO_UNITS*WORD_SIZE  registered read words; FIFO i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- pop_valid  out  FIFO_UNITS  one-cycle pulse per FIFO when its pop_data slice holds a newly popped word.
- empty  out  FIFO_UNITS  occupancy == 0.
- almost_full  out  FIFO_UNITS  occupancy ≥ ALMOST_FULL_LEVEL.
- full  out  FIFO_UNITS  occupancy == FIFO_DEPTH.
- overflow  out  FIFO_UNITS  sticky; set on a dropped push.
- underflow  out  FIFO_UNITS  sticky; set on an ignored pop.

## Operation
- **Per-FIFO state:** wr_ptr and rd_ptr (PTR_W bits each, wrapping naturally mod FIFO_DEPTH), count (PTR_W+1 bits), and a FIFO_DEPTH×WORD_SIZE storage array.
- **Push accepted** when push[i] && (!full[i] || pop[i]):
  - mem[wr_ptr] ← push_data;
  - wr_ptr increments.
- **Pop accepted** when pop[i] && !empty[i]:
  - pop_data slice ← mem[rd_ptr];
  - rd_ptr increments;
  - pop_valid[i] = 1 on the next cycle.
- **count update:** +1 on push only, −1 on pop only, unchanged on both or neither.
- **Full with push and pop in the same cycle:** both are accepted; count stays at FIFO_DEPTH; no overflow.
- **Empty with push and pop in the same cycle:** the push is accepted and the pop is ignored (no bypass); underflow[i] is set; count becomes 1.
- **Push rejected** (full without pop): data is dropped, pointers are unchanged, overflow[i] ← 1.
- **Pop rejected** (empty): pointers are unchanged, pop_valid[i] = 0, underflow[i] ← 1.
- **Multi-hot push:** the same word is written into every accepting FIFO; the bank does not check this case.
- **Flags:** empty, almost_full and full are combinational decodes of the registered count; they carry no dependency on the current push/pop.
- **Sticky bits:** overflow and underflow clear only on reset.

## Timing
- **Pop latency:** pop asserted in cycle N → pop_data/pop_valid valid in cycle N+1.
  - pop_valid is a single-cycle pulse.
  - pop_data holds its last value when there is no pop.
- **Flag latency:** a push or pop in cycle N is reflected in the flags in cycle N+1.
  - The arbiter sees the updated almost_full one cycle after the push that crosses the threshold.
  - ALMOST_FULL_LEVEL therefore carries ≥ 1 entry of headroom.
- **Reset values** (in the cycle after reset is sampled high):
  - pointers and counts 0;
  - empty all-ones;
  - almost_full, full, pop_valid, overflow, underflow all zero;
  - pop_data zero.
- **Reset mid-operation:** contents are discarded. push and pop are ignored in any cycle where reset = 1, including setting of the sticky bits.
- No combinational path from push or pop to any output.

## Structure
- **Shared package** `fifo_bank_pkg`:
  - class field position CLASS_MSB = 9, CLASS_LSB = 8;
  - default WORD_SIZE, FIFO_UNITS, FIFO_DEPTH;
  - the PTR_W derivation function.
- **Sub-module** `sync_fifo`: one FIFO with WORD_SIZE, FIFO_DEPTH and ALMOST_FULL_LEVEL parameters. fifo_bank instantiates FIFO_UNITS copies with a generate loop and only slices the vectors.

## Test plan
- **Reset:** hold reset 2 cycles with push = 4'b1111 → empty = 4'b1111, all other flags 0, pop_data = 0, overflow = 0.
- **Basic FIFO order:** push 0x001..0x003 to FIFO0, then pop ×3 → pop_data[9:0] = 0x001, 0x002, 0x003 on cycles N+1..N+3, with pop_valid[0] pulsing each cycle.
- **Threshold and wrap:**
  - Push 6 words into FIFO2 → almost_full[2] rises the cycle after the 6th push.
  - Push 2 more → full[2] = 1.
  - A 9th push → dropped, overflow[2] = 1.
  - Pop 8 → values returned in order across the pointer wrap.
- **Full with push+pop:** fill FIFO3 to 8, then assert push 0x3AA with pop together → count stays 8, the oldest word is output, no overflow; 0x3AA is read last.
- **Empty with push+pop:** from empty, push 0x155 with pop on FIFO1 → underflow[1] = 1, pop_valid[1] = 0; the next pop returns 0x155.
- **Reset mid-stream:** assert reset with FIFO0 holding 5 words and a pop asserted → empty[0] = 1 afterwards, no pop_valid, sticky bits cleared.

Source files
------------

// File: rtl/fifo_bank_pkg.sv
// Shared definitions for the FIFO bank: word field positions, default
// geometry and the pointer-width derivation used by every FIFO.
package fifo_bank_pkg;

    // Traffic class field inside a word; the rest is payload.
    localparam int CLASS_MSB = 9;
    localparam int CLASS_LSB = 8;

    // Default geometry of the bank.
    localparam int DEF_WORD_SIZE         = 10;
    localparam int DEF_FIFO_UNITS        = 4;
    localparam int DEF_FIFO_DEPTH        = 8;
    localparam int DEF_ALMOST_FULL_LEVEL = 6;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// One synchronous FIFO: registered read port, status flags decoded from the
// registered occupancy, and sticky overflow/underflow indicators.
module sync_fifo
    import fifo_bank_pkg::*;
#(
    parameter int WORD_SIZE         = DEF_WORD_SIZE,
    parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
    parameter int ALMOST_FULL_LEVEL = DEF_ALMOST_FULL_LEVEL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 push,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] pop_data,
    output logic                 pop_valid,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);

    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_AF    = (PTR_W + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;

    logic push_ok;
    logic pop_ok;

    // Flags depend only on the registered count, never on this cycle's requests.
    assign empty       = (count == '0);
    assign full        = (count == CNT_DEPTH);
    assign almost_full = (count >= CNT_AF);

    // A full FIFO still takes a push when a pop frees a slot in the same
    // cycle; an empty FIFO never pops, so there is no write-to-read bypass.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Storage write.
    // NOTE: the array is deliberately not reset; occupancy decides which
    // entries are meaningful, and a resettable array would not map to RAM.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy, read register and sticky error bits.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                pop_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_bank.sv
// Bank of independent FIFOs, one per traffic class. The top only slices the
// shared request/status vectors onto FIFO_UNITS copies of sync_fifo.
module fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int FIFO_UNITS        = DEF_FIFO_UNITS,
    parameter int WORD_SIZE         = DEF_WORD_SIZE,
    parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
    parameter int ALMOST_FULL_LEVEL = DEF_ALMOST_FULL_LEVEL
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WORD_SIZE-1:0]            push_data,
    input  logic [FIFO_UNITS-1:0]           push,
    input  logic [FIFO_UNITS-1:0]           pop,
    output logic [FIFO_UNITS*WORD_SIZE-1:0] pop_data,
    output logic [FIFO_UNITS-1:0]           pop_valid,
    output logic [FIFO_UNITS-1:0]           empty,
    output logic [FIFO_UNITS-1:0]           almost_full,
    output logic [FIFO_UNITS-1:0]           full,
    output logic [FIFO_UNITS-1:0]           overflow,
    output logic [FIFO_UNITS-1:0]           underflow
);

    // One FIFO per class; the write word is broadcast to all of them.
    for (genvar i = 0; i < FIFO_UNITS; i++) begin : g_fifo
        sync_fifo #(
            .WORD_SIZE        (WORD_SIZE),
            .FIFO_DEPTH       (FIFO_DEPTH),
            .ALMOST_FULL_LEVEL(ALMOST_FULL_LEVEL)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push_data  (push_data),
            .push       (push[i]),
            .pop        (pop[i]),
            .pop_data   (pop_data[i*WORD_SIZE +: WORD_SIZE]),
            .pop_valid  (pop_valid[i]),
            .empty      (empty[i]),
            .almost_full(almost_full[i]),
            .full       (full[i]),
            .overflow   (overflow[i]),
            .underflow  (underflow[i])
        );
    end

endmodule
